// File: rtl/key_debounce_if.sv
// key_debounce_if
//  Bundles the key pins and every conditioned key output of key_debounce.
//  Ports / members:
//   key_in       raw key pins, 0 = pressed, asynchronous to the clock
//   key_stable   debounced level, 0 = pressed
//   key_press    1-cycle pulse on a debounced press
//   key_release  1-cycle pulse on a debounced release
//   key_long     1-cycle pulse once per press after the long-press time
//   key_code     0 = nothing pressed, i+1 = lowest-index pressed key i
//  Modports: master = pin/consumer side, slave = the debouncer.
interface key_debounce_if #(
    parameter int NUM_KEYS = 4
);
    logic [NUM_KEYS-1:0] key_in;
    logic [NUM_KEYS-1:0] key_stable;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;
    logic [NUM_KEYS-1:0] key_long;
    logic [2:0]          key_code;

    modport master (
        output key_in,
        input  key_stable, key_press, key_release, key_long, key_code
    );

    modport slave (
        input  key_in,
        output key_stable, key_press, key_release, key_long, key_code
    );
endinterface

// File: rtl/key_debounce.sv
// key_debounce
//  Input conditioner for active-low board keys. Each key is synchronised,
//  debounced, and turned into clean level / press / release / long-press
//  outputs; a registered priority encoder reports the lowest pressed key.
//  Ports:
//   sys_clk   system clock, everything on the rising edge
//   rst_n     synchronous active-low reset
//   bus       key_debounce_if.slave (key_in in, conditioned outputs out)

// One key: 2-flop synchroniser, debounce counter, long-press counter.
module key_debounce_lane #(
    parameter int DEBOUNCE_CYCLES   = 1_000_000,
    parameter int LONG_PRESS_CYCLES = 50_000_000
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic raw,
    output logic stable,
    output logic press,
    output logic rls,
    output logic lng
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int LW = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [DW-1:0] DB_MAX  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] LP_SAT  = LW'(LONG_PRESS_CYCLES - 1);
    localparam logic [LW-1:0] LP_FIRE = LW'(LONG_PRESS_CYCLES - 2);

    logic          s1, s2;
    logic [DW-1:0] db_cnt;
    logic [LW-1:0] lp_cnt;

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            s1     <= 1'b1;
            s2     <= 1'b1;
            stable <= 1'b1;
            db_cnt <= '0;
            lp_cnt <= '0;
            press  <= 1'b0;
            rls    <= 1'b0;
            lng    <= 1'b0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            press <= 1'b0;
            rls   <= 1'b0;
            lng   <= 1'b0;

            // Any return of s2 to the stable level restarts the window.
            if (s2 == stable) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_MAX) begin
                db_cnt <= '0;
                stable <= s2;
                press  <= ~s2;
                rls    <= s2;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end

            // Cleared during the press pulse so the long-press time is
            // measured from the press event; saturating stops repeats.
            if (stable || press) begin
                lp_cnt <= '0;
            end else if (lp_cnt != LP_SAT) begin
                lp_cnt <= lp_cnt + 1'b1;
                lng    <= (lp_cnt == LP_FIRE);
            end
        end
    end
endmodule

module key_debounce #(
    parameter int NUM_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES   = 1_000_000,
    parameter int LONG_PRESS_CYCLES = 50_000_000
) (
    input  logic           sys_clk,
    input  logic           rst_n,
    key_debounce_if.slave  bus
);
    logic [NUM_KEYS-1:0] stable_w;
    logic [NUM_KEYS-1:0] press_w;
    logic [NUM_KEYS-1:0] rls_w;
    logic [NUM_KEYS-1:0] lng_w;
    logic [2:0]          code_nxt;
    logic [2:0]          code_q;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_lane
        key_debounce_lane #(
            .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
            .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
        ) u_lane (
            .sys_clk(sys_clk),
            .rst_n  (rst_n),
            .raw    (bus.key_in[g]),
            .stable (stable_w[g]),
            .press  (press_w[g]),
            .rls    (rls_w[g]),
            .lng    (lng_w[g])
        );
    end

    // Scan from the top so the lowest pressed index wins.
    always_comb begin
        code_nxt = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (!stable_w[i]) code_nxt = 3'(i + 1);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) code_q <= '0;
        else        code_q <= code_nxt;
    end

    assign bus.key_stable  = stable_w;
    assign bus.key_press   = press_w;
    assign bus.key_release = rls_w;
    assign bus.key_long    = lng_w;
    assign bus.key_code    = code_q;
endmodule
